switch_digit_display: RTL and testbench
=======================================

// Module: switch_digit_display
// PURPOSE
//  Parametrised switch-status display for the board I/O layer: each of NUM_CH slide
//  switches is synchronised and debounced, its state driven on an LED and its 7-seg
//  digit. In count mode each digit shows that channel's rising-edge count (mod 10).
//  Sits directly between board pins SW/LEDR/HEX and the rest of the top level.
// PARAMETERS
//  NUM_CH           6       number of switch/LED/digit channels (1..10)
//  DEBOUNCE_CYCLES  500000  consecutive stable samples needed to accept a change (>=2; 10 ms @ 50 MHz)
// PORTS
//  CLOCK_50  in   1         system clock, all state on rising edge
//  RESET     in   1         asynchronous, active-high reset
//  SW        in   NUM_CH    raw slide switches (asynchronous, bouncy); up = 1
//  MODE      in   1         raw switch: 0 = state mode, 1 = count mode
//  CLR_CNT   in   1         synchronous clear of all edge counters (already clean)
//  LEDR      out  NUM_CH    debounced switch state, 1 = lit
//  HEX       out  8*NUM_CH  active-low segments; HEX[8i+7:8i] = digit i, bit7 = dp, bits6..0 = g..a
// BEHAVIOUR
//  Reset (async, held): sync FFs, debounce counters, stable state, edge counters = 0;
//   LEDR = 0; every HEX byte = 8'hC0 ("0", dp off). Release on next clock edge.
//  Sync: SW and MODE each pass through 2 FFs; MODE is not debounced.
//  Debounce per channel: sample s (synced) vs stable q.
//   s == q -> counter cleared. s != q -> counter++; on the cycle the counter reaches
//   DEBOUNCE_CYCLES-1 with s still != q, q <= s and counter cleared.
//   Any s==q sample mid-count restarts it; a pulse shorter than DEBOUNCE_CYCLES cycles
//   never changes q. Counter width = $clog2(DEBOUNCE_CYCLES).
//  Latency: pin change to LEDR = 2 (sync) + DEBOUNCE_CYCLES clocks; LEDR is q itself.
//  Edge counter per channel (4 bit, 0..9): q 0->1 increments; 9 wraps to 0.
//   CLR_CNT high clears all counters; wins over a same-cycle increment. 1->0 ignored.
//  HEX is registered: updates one clock after q / counter / synced MODE change.
//   Mode 0: digit = q ? 8'hF9 : 8'hC0. Mode 1: digit = glyph(counter).
//   glyph 0..9 = C0 F9 A4 B0 99 92 82 F8 80 90; dp always off (bit7 = 1).
//  Channels fully independent; simultaneous changes on all channels handled in parallel.
//  MODE switch is display-only: never alters q or counters.
//  Reset mid-debounce: pending change discarded, q = 0; switch held up after release is
//   re-accepted after the full 2 + DEBOUNCE_CYCLES latency (counts as a rising edge).
// STRUCTURE
//  Package seg7_pkg: localparam SEG_OFF/glyph constants 0..9 (active-low, 8 bit) and
//   function seg7_glyph(input [3:0]) returning 8'hFF (blank) for 10..15.
//  Sub-module switch_debouncer (#DEBOUNCE_CYCLES): 1-bit 2-FF sync + counter + q, plus
//   one-cycle rise pulse output; instantiated NUM_CH times via generate.
//  Top: generate loop of debouncer + edge counter + HEX register; shared MODE sync.
// TESTING  (bench uses NUM_CH=6, DEBOUNCE_CYCLES=4)
//  1 Assert RESET mid-run with SW=6'h3F -> LEDR=0, all HEX bytes 8'hC0 same cycle (async).
//  2 SW[0] 0->1 held -> LEDR[0]=1 exactly 6 clocks later, HEX[7:0]=8'hF9 at clock 7.
//  3 SW[1] high for 3 clocks then low -> LEDR[1] and HEX[15:8] never change.
//  4 MODE=1, 12 clean rising edges on SW[2] -> HEX[23:16] shows 8'hA4 ("2");
//    after 10th edge shows 8'hC0 (wrap).
//  5 CLR_CNT pulsed in same cycle q[3] rises -> channel 3 count = 0, HEX[31:24]=8'hC0.
//  6 All 6 switches toggled together, bounce on SW[5] only -> channels 0..4 update at
//    clock 6, channel 5 only after 4 stable samples; MODE 0->1->0 leaves LEDR unchanged.

Source files
------------

// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and lookup shared by the switch display.
// Encoding is active-low, bit7 = dp, bits6..0 = g..a; dp is always left off.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;

  // Decimal digit to glyph; 10..15 never occur on a mod-10 counter, shown blank.
  function automatic logic [7:0] seg7_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch channel: 2-FF synchroniser, stability counter and accepted state.
//  clk   in   system clock
//  rst   in   async active-high reset
//  raw   in   raw (asynchronous, bouncy) switch pin
//  q     out  debounced state
//  rise  out  one-cycle pulse in the cycle whose closing edge takes q 0->1
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s;
  logic [CW-1:0] cnt;
  logic          hit;

  // Sample disagrees with q for the DEBOUNCE_CYCLES-th consecutive cycle.
  assign hit  = (s != q) && (cnt == CNT_LAST);
  // Exposed one cycle early so the edge counter steps on the same edge as q.
  assign rise = hit & s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      q   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s  <= s1;
      if (s == q) begin
        cnt <= '0;
      end else if (hit) begin
        q   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_digit_display.sv
// Switch-status display: per channel a debounced switch drives an LED and a
// 7-seg digit. MODE=0 shows the state (0/1), MODE=1 the rising-edge count mod 10.
//  CLOCK_50  in   system clock
//  RESET     in   async active-high reset
//  SW        in   raw slide switches, up = 1
//  MODE      in   raw mode switch (synchronised, not debounced)
//  CLR_CNT   in   clean synchronous clear of all edge counters
//  LEDR      out  debounced switch states
//  HEX       out  active-low digits, HEX[8i+7:8i] = digit i
module switch_digit_display
  import seg7_pkg::*;
#(
  parameter int NUM_CH          = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [NUM_CH-1:0]     SW,
  input  logic                  MODE,
  input  logic                  CLR_CNT,
  output logic [NUM_CH-1:0]     LEDR,
  output logic [8*NUM_CH-1:0]   HEX
);

  logic                  mode_s1, mode_s;
  logic [NUM_CH-1:0]     q;
  logic [NUM_CH-1:0]     rise;
  logic [NUM_CH-1:0][7:0] hex_bytes;

  // MODE only selects the glyph source, so a plain 2-FF sync is enough.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      mode_s1 <= 1'b0;
      mode_s  <= 1'b0;
    end else begin
      mode_s1 <= MODE;
      mode_s  <= mode_s1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [3:0] cnt;
    logic [7:0] hex_q;

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (CLOCK_50),
      .rst  (RESET),
      .raw  (SW[i]),
      .q    (q[i]),
      .rise (rise[i])
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
        cnt   <= 4'd0;
        hex_q <= SEG_0;
      end else begin
        // Clear takes priority over a same-cycle rising edge.
        if (CLR_CNT)
          cnt <= 4'd0;
        else if (rise[i])
          cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        hex_q <= mode_s ? seg7_glyph(cnt) : (q[i] ? SEG_1 : SEG_0);
      end
    end

    assign hex_bytes[i] = hex_q;
  end

  assign LEDR = q;
  assign HEX  = hex_bytes;

endmodule

// File: tb/tb_switch_digit_display.sv
module tb_switch_digit_display;

  logic        clk = 1'b0;
  logic        rst, mode, clr;
  logic [5:0]  sw, ledr;
  logic [47:0] hex;

  always #5 clk = ~clk;

  switch_digit_display #(.NUM_CH(6), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW       (sw),
    .MODE     (mode),
    .CLR_CNT  (clr),
    .LEDR     (ledr),
    .HEX      (hex)
  );

  typedef struct {
    string       name;
    logic [5:0]  lm, le;
    logic [47:0] hm, he;
  } exp_t;

  typedef struct {
    logic [5:0]  sw;
    logic        mode, clr;
    logic [5:0]  ledr;
    logic [47:0] hex;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] gly [10];

  localparam logic [47:0] ALL_C0 = 48'hC0C0_C0C0_C0C0;

  task automatic push(string nm, logic [5:0] lm, logic [5:0] le,
                      logic [47:0] hm, logic [47:0] he);
    exp_t e;
    e.name = nm; e.lm = lm; e.le = le; e.hm = hm; e.he = he;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    if ((((ledr ^ e.le) & e.lm) !== 6'd0) || (((hex ^ e.he) & e.hm) !== 48'd0)) begin
      n_err++;
      $display("FAIL %s: got ledr=%h hex=%h, want ledr=%h hex=%h (masks %h/%h) t=%0t",
               e.name, ledr, hex, e.le, e.he, e.lm, e.hm, $time);
    end
  endtask

  task automatic expect_all(string nm, logic [5:0] le, logic [47:0] he);
    push(nm, 6'h3F, le, {48{1'b1}}, he);
    check();
  endtask

  // Advance n rising edges, ending on a falling edge (sample/drive point).
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [47:0] bmask(int i);
    logic [47:0] m;
    m = 48'hFF;
    return m << (8 * i);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic [47:0] g;
    int bounce[13];

    gly = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Steady-state vectors, 10 clocks each (longer than the 7-clock latency).
    tbl[0] = '{6'h00, 1'b0, 1'b0, 6'h00, ALL_C0};
    tbl[1] = '{6'h05, 1'b0, 1'b0, 6'h05, 48'hC0C0_C0F9_C0F9};
    tbl[2] = '{6'h00, 1'b1, 1'b0, 6'h00, 48'hC0C0_C0F9_C0F9};
    tbl[3] = '{6'h01, 1'b1, 1'b0, 6'h01, 48'hC0C0_C0F9_C0A4};
    tbl[4] = '{6'h00, 1'b1, 1'b1, 6'h00, ALL_C0};
    tbl[5] = '{6'h2A, 1'b1, 1'b0, 6'h2A, 48'hF9C0_F9C0_F9C0};
    tbl[6] = '{6'h00, 1'b0, 1'b0, 6'h00, ALL_C0};
    tbl[7] = '{6'h00, 1'b1, 1'b0, 6'h00, 48'hF9C0_F9C0_F9C0};
    tbl[8] = '{6'h00, 1'b0, 1'b1, 6'h00, ALL_C0};

    // SW[5] bounce before posedge k: 1,0,1,1,0 then held high.
    bounce = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};

    rst = 1'b1; sw = 6'h00; mode = 1'b0; clr = 1'b0;
    @(negedge clk);
    cyc(3);
    expect_all("reset_state", 6'h00, ALL_C0);
    rst = 1'b0;

    // Table-driven steady-state section.
    for (int v = 0; v < 9; v++) begin
      sw = tbl[v].sw; mode = tbl[v].mode; clr = tbl[v].clr;
      push($sformatf("table_%0d", v), 6'h3F, tbl[v].ledr, {48{1'b1}}, tbl[v].hex);
      cyc(10);
      check();
    end
    clr = 1'b0;

    // SW[0] rise: LEDR at clock 6, HEX byte 0 at clock 7.
    sw[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      push($sformatf("sw0_latency_clk%0d", k), 6'h01, (k >= 6) ? 6'h01 : 6'h00,
           bmask(0), (k >= 7) ? 48'hF9 : 48'hC0);
      check();
    end

    // SW[1] glitch of 3 clocks never accepted.
    sw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) sw[1] = 1'b0;
      cyc(1);
      push($sformatf("sw1_glitch_clk%0d", k), 6'h02, 6'h00, bmask(1), 48'hC0 << 8);
      check();
    end

    // Count mode: ch0 already counted once.
    mode = 1'b1;
    cyc(4);
    expect_all("count_mode_entry", 6'h01, 48'hC0C0_C0C0_C0F9);

    // 12 clean rising edges on SW[2] with wrap after the 10th.
    for (int k = 1; k <= 12; k++) begin
      sw[2] = 1'b1;
      cyc(8);
      g = {40'd0, gly[k % 10]};
      push($sformatf("sw2_edge%0d", k), 6'h04, 6'h04, bmask(2), g << 16);
      check();
      sw[2] = 1'b0;
      cyc(8);
    end

    // CLR_CNT in the cycle whose edge raises q[3]: clear wins, all counts 0.
    sw[3] = 1'b1;
    cyc(5);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    push("clr_vs_rise_ledr", 6'h08, 6'h08, 48'd0, 48'd0);
    check();
    cyc(2);
    expect_all("clr_vs_rise_hex", 6'h09, ALL_C0);

    // All channels toggle; SW[5] bounces. State mode.
    mode = 1'b0;
    cyc(4);
    for (int k = 1; k <= 12; k++) begin
      sw = {bounce[k] != 0, 5'b10110};
      cyc(1);
      push($sformatf("toggle_all_clk%0d", k), 6'h3F,
           (k < 6) ? 6'h09 : (k < 11) ? 6'h16 : 6'h36, 48'd0, 48'd0);
      check();
    end
    expect_all("toggle_all_hex", 6'h36, 48'hF9F9_C0F9_F9C0);
    mode = 1'b1;
    cyc(4);
    expect_all("mode1_no_effect", 6'h36, 48'hF9F9_C0F9_F9C0);
    mode = 1'b0;
    cyc(4);
    expect_all("mode0_no_effect", 6'h36, 48'hF9F9_C0F9_F9C0);

    // Mid-run async reset with all switches up.
    sw = 6'h3F; mode = 1'b1;
    cyc(10);
    expect_all("all_up_counts", 6'h3F, 48'hF9F9_F9F9_F9F9);
    #2 rst = 1'b1;
    #1 expect_all("async_reset", 6'h00, ALL_C0);
    @(negedge clk);
    cyc(1);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      push($sformatf("reaccept_clk%0d", k), 6'h3F, (k >= 6) ? 6'h3F : 6'h00, 48'd0, 48'd0);
      check();
    end
    cyc(4);
    expect_all("reaccept_counts", 6'h3F, 48'hF9F9_F9F9_F9F9);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d expectations unchecked", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
